// File: rtl/free_list.sv
// free_list
//   Free physical-register list for a register-renaming front end. At reset
//   every physical register above the architectural ones (NUM_ARCH_REGS ..
//   NUM_ARCH_REGS+DEPTH-1) is free, so the list starts full. The rename stage
//   takes registers from the head. The ROB returns freed registers at the tail.
//
//   Handshake semantics (both sides are valid/ready style):
//     - Dequeue side: "valid" is !is_free_list_empty and "ready" is dequeue.
//       phys_reg is the head entry with zero read latency. A transfer happens
//       on a rising edge where dequeue && !is_free_list_empty. A dequeue
//       while empty is ignored. There is no bypass from enqueue_reg.
//     - Enqueue side: "valid" is enqueue and "ready" is "not full". A transfer
//       happens on a rising edge where enqueue && !full. An enqueue while full
//       is dropped and sets the sticky overflow flag until reset.
//
//   Optional feature: define FREE_LIST_FLUSH_EN to add the flush port. A
//   flush moves head back to retire_head, which includes that cycle's enqueue.
//   This reclaims every speculatively dequeued register. A flush overrides a
//   dequeue in the same cycle. An enqueue in that cycle is still written.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   dequeue             rename stage consumes phys_reg this cycle
//   phys_reg            free register at the head of the list
//   is_free_list_empty  no free entry available
//   enqueue             ROB commit returns a freed register
//   enqueue_reg         the freed register
//   flush               mispredict recovery (FREE_LIST_FLUSH_EN only)
//   overflow            sticky: an enqueue arrived while the list was full
module free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_ARCH_REGS = 32,
  parameter int DEPTH         = 2**PHYS_REG_BITS - NUM_ARCH_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] phys_reg,
  output logic                     is_free_list_empty,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] enqueue_reg,
`ifdef FREE_LIST_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic                     full;
  logic                     deq_ok;
  logic                     enq_ok;

  // The pointer MSB is a wrap bit. The index bits roll from DEPTH-1 to 0
  // explicitly, so a DEPTH that is not a power of two still works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
      return {~p[PTR_W-1], {IDX_W{1'b0}}};
    else
      return p + PTR_W'(1);
  endfunction

  assign is_free_list_empty = (head == tail);
  assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                    (head[PTR_W-1] != tail[PTR_W-1]);
  assign deq_ok   = dequeue && !is_free_list_empty;
  assign enq_ok   = enqueue && !full;
  assign phys_reg = mem[head[IDX_W-1:0]];

  // Storage. Reset reloads the initial free registers, so a write in
  // progress when rst asserts is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
    end else if (enq_ok) begin
      mem[tail[IDX_W-1:0]] <= enqueue_reg;
    end
  end

  // Tail starts with the wrap bit set: head and tail indices match, wraps differ -> full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tail <= {1'b1, {IDX_W{1'b0}}};
    else if (enq_ok)
      tail <= ptr_inc(tail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (enqueue && full)
      overflow <= 1'b1;
  end

`ifdef FREE_LIST_FLUSH_EN
  // retire_head advances with each enqueue. It is the recovery point that
  // head returns to on a flush.
  logic [PTR_W-1:0] retire_head;
  logic [PTR_W-1:0] retire_head_next;

  always_comb begin
    retire_head_next = retire_head;
    if (enq_ok)
      retire_head_next = ptr_inc(retire_head);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retire_head <= '0;
    else
      retire_head <= retire_head_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      head <= '0;
    else if (flush)
      head <= retire_head_next;
    else if (deq_ok)
      head <= ptr_inc(head);
  end
`else
  // Without flush recovery nothing reads retire_head, so only head and tail
  // are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      head <= '0;
    else if (deq_ok)
      head <= ptr_inc(head);
  end
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int PRB   = 6;
  localparam int NARCH = 32;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dequeue = 1'b0;
  logic           enqueue = 1'b0;
  logic [PRB-1:0] enqueue_reg = '0;
  logic           flush = 1'b0;
  logic [PRB-1:0] phys_reg;
  logic           is_free_list_empty;
  logic           overflow;

  always #5 clk = ~clk;

  free_list #(.PHYS_REG_BITS(PRB), .NUM_ARCH_REGS(NARCH), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .dequeue            (dequeue),
    .phys_reg           (phys_reg),
    .is_free_list_empty (is_free_list_empty),
    .enqueue            (enqueue),
    .enqueue_reg        (enqueue_reg),
`ifdef FREE_LIST_FLUSH_EN
    .flush              (flush),
`endif
    .overflow           (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the free registers in the order they should be handed out.
  logic [PRB-1:0] exp_q[$];
  bit             exp_ovf;
  int             n_checks = 0;
  int             n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(PRB'(NARCH + i));
    exp_ovf = 1'b0;
  endtask

  // Update the model with the rules that apply when the edge samples these inputs.
  task automatic model_step(input bit d, input bit e, input logic [PRB-1:0] r);
    int sz;
    sz = exp_q.size();
    if (e && sz == DEPTH) exp_ovf = 1'b1;
    if (d && sz > 0) void'(exp_q.pop_front());
    if (e && sz < DEPTH) exp_q.push_back(r);
  endtask

  // Compare the DUT outputs with the model.
  task automatic check_model(input string tag);
    check({tag, ".empty"}, 32'(is_free_list_empty), 32'(exp_q.size() == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() > 0) check({tag, ".head"}, 32'(phys_reg), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge. Outputs are sampled at the same point.
  task automatic tick(input bit d, input bit e, input logic [PRB-1:0] r);
    dequeue = d; enqueue = e; enqueue_reg = r;
    model_step(d, e, r);
    @(posedge clk); #1;
    dequeue = 1'b0; enqueue = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Reset state
    check("rst.phys_reg", 32'(phys_reg), 32'd32);
    check("rst.empty", 32'(is_free_list_empty), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);

    // Drain in order: 32..63, then the list is empty
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 32'(phys_reg), 32'(NARCH + i));
      tick(1'b1, 1'b0, '0);
    end
    check("drain.empty", 32'(is_free_list_empty), 32'd1);

    // A dequeue while empty is ignored. The enqueue that same cycle is still accepted.
    tick(1'b1, 1'b1, PRB'(5));
    check("empty_bypass.phys_reg", 32'(phys_reg), 32'd5);
    check("empty_bypass.empty", 32'(is_free_list_empty), 32'd0);
    check_model("empty_bypass");

    // Overflow on a full list. The contents must stay unchanged.
    do_reset();
    tick(1'b0, 1'b1, PRB'(7));
    check("ovf.set", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf.contents", 32'(phys_reg), 32'(NARCH + i));
      tick(1'b1, 1'b0, '0);
    end
    check("ovf.sticky", 32'(overflow), 32'd1);
    check("ovf.empty", 32'(is_free_list_empty), 32'd1);

    // Pointer wrap: enqueue 10..49, each one followed by a dequeue
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, '0);
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, PRB'(10 + i));
      check("wrap.order", 32'(phys_reg), 32'(10 + i));
      tick(1'b1, 1'b0, '0);
    end
    check("wrap.empty", 32'(is_free_list_empty), 32'd1);

    // An asynchronous reset mid-stream takes effect without waiting for a clock edge
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0);
    check("pre_arst.phys_reg", 32'(phys_reg), 32'd42);
    #3 rst = 1'b1;
    #1;
    check("arst.phys_reg", 32'(phys_reg), 32'd32);
    check("arst.empty", 32'(is_free_list_empty), 32'd0);
    check("arst.ovf", 32'(overflow), 32'd0);
    do_reset();

`ifdef FREE_LIST_FLUSH_EN
    // Flush recovery: head returns to retire_head (1). Occupancy is 32 again.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, PRB'(9));
    flush = 1'b1;
    dequeue = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dequeue = 1'b0;
    check("flush.phys_reg", 32'(phys_reg), 32'd33);
    check("flush.empty", 32'(is_free_list_empty), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("flush.order", 32'(phys_reg), (i < DEPTH - 1) ? 32'(33 + i) : 32'd9);
      dequeue = 1'b1;
      @(posedge clk); #1;
      dequeue = 1'b0;
    end
    check("flush.drained", 32'(is_free_list_empty), 32'd1);
    do_reset();
`endif

    // Randomized traffic checked against the model. Dequeue and enqueue rates
    // vary by phase so the list swings between empty and full.
    for (int ph = 0; ph < 4; ph++) begin
      int pd, pe;
      pd = (ph % 2 == 0) ? 70 : 30;
      pe = (ph % 2 == 0) ? 30 : 70;
      for (int c = 0; c < 400; c++) begin
        bit d, e;
        d = ($urandom_range(99) < pd);
        e = ($urandom_range(99) < pe);
        tick(d, e, PRB'($urandom_range(63)));
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected completion");
    $fatal(1, "timeout");
  end

endmodule
